// File: rtl/csel_adder_pipe.sv
// csel_adder_pipe -- two-stage pipelined carry-select adder/subtractor.
//
// The operands are split into BLOCK-bit groups. In the first stage every group
// except group 0 computes two candidate sums, one for carry-in 0 and one for
// carry-in 1. Group 0 computes its real sum directly. After the first register,
// the real carry ripples group to group and picks one candidate per group. The
// result, carry and signed overflow are then registered onto the outputs.
// A valid/ready handshake on both sides gives one beat per cycle when the
// downstream is ready.
//
// Optional feature: define CSEL_SATURATE_EN to add the 'sat' input. A beat
// captured with sat=1 that overflows is clamped to the signed limit.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present
//   in_ready   block accepts operands this cycle
//   a, b       operands (WIDTH bits)
//   sub        0: a+b+cin, 1: a-b computed as a+~b+1 (cin ignored)
//   cin        carry-in for add mode
//   sat        (CSEL_SATURATE_EN only) clamp on signed overflow
//   out_valid  result present
//   out_ready  downstream accepts the result
//   sum        result (WIDTH bits, modulo 2^WIDTH unless clamped)
//   carry      carry out of the MSB; in subtract mode 1 means no borrow
//   overflow   signed overflow flag
module csel_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
`ifdef CSEL_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int NBLK  = WIDTH / BLOCK;
  localparam int NCAND = NBLK - 1;

`ifdef CSEL_SATURATE_EN
  // Largest positive value for neg=0, most negative value for neg=1.
  function automatic logic signed [WIDTH-1:0] sat_limit(input logic neg);
    logic signed [WIDTH-1:0] lim;
    lim = {neg, {(WIDTH-1){!neg}}};
    return lim;
  endfunction
`endif

  logic vld_p1;
  logic adv1, adv2;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;

  // ---- stage 0: operand conditioning and per-group candidate sums ----
  logic [WIDTH-1:0]             bx_p0;
  logic                         cin_p0;
  logic [BLOCK-1:0]             g0_sum_p0;
  logic                         g0_cy_p0;
  logic [NCAND-1:0][BLOCK-1:0]  sum0_p0, sum1_p0;
  logic [NCAND-1:0]             cy0_p0, cy1_p0;

  always_comb begin
    bx_p0  = sub ? ~b : b;
    cin_p0 = sub | cin;
    {g0_cy_p0, g0_sum_p0} = {1'b0, a[BLOCK-1:0]} + {1'b0, bx_p0[BLOCK-1:0]}
                          + {{BLOCK{1'b0}}, cin_p0};
    for (int g = 1; g < NBLK; g++) begin
      {cy0_p0[g-1], sum0_p0[g-1]} = {1'b0, a[g*BLOCK +: BLOCK]}
                                  + {1'b0, bx_p0[g*BLOCK +: BLOCK]};
      {cy1_p0[g-1], sum1_p0[g-1]} = {1'b0, a[g*BLOCK +: BLOCK]}
                                  + {1'b0, bx_p0[g*BLOCK +: BLOCK]}
                                  + {{BLOCK{1'b0}}, 1'b1};
    end
  end

  // ---- stage 1 register: candidates plus sign bits ----
  // bx_msb already reflects the subtract inversion, so sub itself is not
  // needed past this point.
  logic [BLOCK-1:0]             g0_sum_p1;
  logic                         g0_cy_p1;
  logic [NCAND-1:0][BLOCK-1:0]  sum0_p1, sum1_p1;
  logic [NCAND-1:0]             cy0_p1, cy1_p1;
  logic                         a_msb_p1, bx_msb_p1;
`ifdef CSEL_SATURATE_EN
  logic                         sat_p1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      g0_sum_p1 <= '0;
      g0_cy_p1  <= 1'b0;
      sum0_p1   <= '0;
      sum1_p1   <= '0;
      cy0_p1    <= '0;
      cy1_p1    <= '0;
      a_msb_p1  <= 1'b0;
      bx_msb_p1 <= 1'b0;
`ifdef CSEL_SATURATE_EN
      sat_p1    <= 1'b0;
`endif
    end else begin
      if (adv1) vld_p1 <= in_valid;
      if (adv1 && in_valid) begin
        g0_sum_p1 <= g0_sum_p0;
        g0_cy_p1  <= g0_cy_p0;
        sum0_p1   <= sum0_p0;
        sum1_p1   <= sum1_p0;
        cy0_p1    <= cy0_p0;
        cy1_p1    <= cy1_p0;
        a_msb_p1  <= a[WIDTH-1];
        bx_msb_p1 <= bx_p0[WIDTH-1];
`ifdef CSEL_SATURATE_EN
        sat_p1    <= sat;
`endif
      end
    end
  end

  // ---- stage 2: carry chain selects one candidate per group ----
  logic signed [WIDTH-1:0] res_p2;
  logic signed [WIDTH-1:0] sum_p2;
  logic                    c_sel;
  logic                    ovf_p2;

  always_comb begin
    c_sel  = g0_cy_p1;
    res_p2 = '0;
    res_p2[BLOCK-1:0] = g0_sum_p1;
    for (int g = 1; g < NBLK; g++) begin
      res_p2[g*BLOCK +: BLOCK] = c_sel ? sum1_p1[g-1] : sum0_p1[g-1];
      c_sel = c_sel ? cy1_p1[g-1] : cy0_p1[g-1];
    end
    ovf_p2 = (a_msb_p1 == bx_msb_p1) && (res_p2[WIDTH-1] != a_msb_p1);
    sum_p2 = res_p2;
`ifdef CSEL_SATURATE_EN
    if (sat_p1 && ovf_p2) sum_p2 = sat_limit(a_msb_p1);
`endif
  end

  // ---- output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (adv2) out_valid <= vld_p1;
      if (adv2 && vld_p1) begin
        sum      <= sum_p2;
        carry    <= c_sel;
        overflow <= ovf_p2;
      end
    end
  end

endmodule
